// File: rtl/birth_digit_sequencer.sv
// birth_digit_sequencer
// Drives the birthday digit generator's index, captures the eight returned
// BCD digits into a buffer, then scans the buffer onto a multiplexed,
// active-low-anode 7-segment display.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero positions
// (the rightmost position is always shown).

module birth_digit_sequencer #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    output logic [2:0]        idx,
    input  logic [3:0]        digit_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SCAN
    } state_t;

    localparam logic [2:0]        LAST_IDX = 3'(DIGITS - 1);
    localparam logic [7:0]        DIV_LAST = 8'(SCAN_DIV - 1);
    localparam logic [DIGITS-1:0] AN_ONE   = DIGITS'(1);

    state_t     state;
    state_t     next_state;
    logic [3:0] digit_buf [DIGITS];
    logic [2:0] pos;
    logic [7:0] cnt;

    // Seven-segment pattern {a,b,c,d,e,f,g}; the 4'hF error marker shows a dash
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1111110;
            4'd1:    decode = 7'b0110000;
            4'd2:    decode = 7'b1101101;
            4'd3:    decode = 7'b1111001;
            4'd4:    decode = 7'b0110011;
            4'd5:    decode = 7'b1011011;
            4'd6:    decode = 7'b1011111;
            4'd7:    decode = 7'b1110000;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1111011;
            default: decode = 7'b0000001;
        endcase
    endfunction

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: start is only honoured when idle or scanning
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   next_state = CAPTURE;
            CAPTURE: next_state = (idx == LAST_IDX) ? SCAN : FETCH;
            SCAN:    if (start) next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Load datapath, status flags and scan position/divider
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            pos  <= '0;
            cnt  <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                digit_buf[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx  <= '0;
                        busy <= 1'b1;
                        err  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (digit_in <= 4'd9) begin
                        digit_buf[idx] <= digit_in;
                    end else begin
                        digit_buf[idx] <= 4'hF;
                        err            <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        pos  <= '0;
                        cnt  <= '0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                SCAN: begin
                    if (start) begin
                        idx  <= '0;
                        busy <= 1'b1;
                        err  <= 1'b0;
                    end else if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        pos <= (pos == LAST_IDX) ? 3'd0 : pos + 3'd1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lead_zero;

    // A position is a leading zero when it and everything to its left is zero
    always_comb begin
        lead_zero = 1'b1;
        for (int q = 0; q < DIGITS; q++) begin
            if (q <= int'(pos) && digit_buf[q] != 4'd0) begin
                lead_zero = 1'b0;
            end
        end
        if (pos == LAST_IDX) begin
            lead_zero = 1'b0;
        end
    end
`endif

    // Display drive: blank outside SCAN, otherwise enable the current position
    always_comb begin
        seg = 7'b0000000;
        an  = '1;
        if (state == SCAN) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (!lead_zero) begin
                seg = decode(digit_buf[pos]);
                an  = ~(AN_ONE << pos);
            end
`else
            seg = decode(digit_buf[pos]);
            an  = ~(AN_ONE << pos);
`endif
        end
    end

endmodule

// File: tb/tb_birth_digit_sequencer.sv
// tb_birth_digit_sequencer
// Self-checking bench for birth_digit_sequencer: table-driven loads, hand
// sequences for reset/restart corners, and randomized loads compared against
// a digit-list model of what the display should show.

module tb_birth_digit_sequencer;

    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 4;

    logic              CLK;
    logic              RST_N;
    logic              start;
    logic [2:0]        idx;
    logic [3:0]        digit_in;
    logic              busy;
    logic              done;
    logic              err;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    logic [3:0] gen_mem [8];
    logic [6:0] seg_table [16];

    int testsRun;
    int failures;

    typedef struct {
        logic [31:0] digits;
        logic        expErr;
        logic [6:0]  expSeg0;
        logic [6:0]  expSeg3;
        int          restartAt;
    } vec_t;

    vec_t vecs [3];

    birth_digit_sequencer #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start),
        .idx      (idx),
        .digit_in (digit_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .seg      (seg),
        .an       (an)
    );

    // Generator model: combinational lookup on the index
    assign digit_in = gen_mem[idx];

    // Free-running clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] pack8(input int d0, input int d1, input int d2, input int d3,
                                          input int d4, input int d5, input int d6, input int d7);
        logic [31:0] w;
        w = {4'(d7), 4'(d6), 4'(d5), 4'(d4), 4'(d3), 4'(d2), 4'(d1), 4'(d0)};
        return w;
    endfunction

    // Value the buffer should hold for a generator digit
    function automatic logic [3:0] captured(input logic [31:0] digits, input int i);
        logic [3:0] d;
        d = digits[4*i +: 4];
        return (d > 4'd9) ? 4'hF : d;
    endfunction

    function automatic logic expectErr(input logic [31:0] digits);
        logic e;
        e = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits[4*i +: 4] > 4'd9) e = 1'b1;
        end
        return e;
    endfunction

    function automatic logic isBlank(input logic [31:0] digits, input int p);
        logic b;
        b = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (p < DIGITS - 1) begin
            b = 1'b1;
            for (int q = 0; q <= p; q++) begin
                if (captured(digits, q) != 4'd0) b = 1'b0;
            end
        end
`endif
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Load the generator, pulse start, optionally re-pulse start mid-load, wait for done
    task automatic applyStimulus(input logic [31:0] digits, input int restartAt);
        int c;
        bit seen;
        for (int i = 0; i < 8; i++) gen_mem[i] = digits[4*i +: 4];
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checkOutput("busy_rise", busy, 1);
        checkOutput("done_low_at_start", done, 0);
        checkOutput("idx_at_start", idx, 0);
        checkOutput("err_cleared", err, 0);
        checkOutput("an_blank_loading", an, 8'hFF);
        checkOutput("seg_blank_loading", seg, 0);
        seen = 1'b0;
        c = 0;
        while (!seen && c < 40) begin
            if (c + 1 == restartAt) start = 1'b1;
            @(negedge CLK);
            start = 1'b0;
            c++;
            if (done) begin
                seen = 1'b1;
            end else begin
                checkOutput("busy_during_load", busy, 1);
                checkOutput("idx_during_load", idx, (c / 2 > 7) ? 7 : c / 2);
            end
        end
        checkOutput("done_latency", c, 16);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("err_after_load", err, expectErr(digits));
    endtask

    // Watch the scan for several full rotations against the digit-list model
    task automatic checkScan(input logic [31:0] digits, input int cycles, output logic [6:0] seg3);
        int p;
        logic [6:0] es;
        logic [7:0] ea;
        seg3 = 7'h7F;
        for (int t = 0; t < cycles; t++) begin
            p = (t / SCAN_DIV) % DIGITS;
            if (isBlank(digits, p)) begin
                es = 7'b0000000;
                ea = 8'hFF;
            end else begin
                es = seg_table[captured(digits, p)];
                ea = ~(8'd1 << p);
            end
            checkOutput($sformatf("scan_an_t%0d", t), an, ea);
            checkOutput($sformatf("scan_seg_t%0d", t), seg, es);
            if (t == 1) checkOutput("done_one_cycle", done, 0);
            if (t == 2) checkOutput("idx_hold_scan", idx, 7);
            if (t == 12) seg3 = seg;
            @(negedge CLK);
        end
    endtask

    initial begin
        logic [6:0]  s3;
        logic [31:0] rd;
        bit          doneSeen;
        testsRun = 0;
        failures = 0;

        seg_table[0]  = 7'b1111110; seg_table[1]  = 7'b0110000;
        seg_table[2]  = 7'b1101101; seg_table[3]  = 7'b1111001;
        seg_table[4]  = 7'b0110011; seg_table[5]  = 7'b1011011;
        seg_table[6]  = 7'b1011111; seg_table[7]  = 7'b1110000;
        seg_table[8]  = 7'b1111111; seg_table[9]  = 7'b1111011;
        for (int i = 10; i < 15; i++) seg_table[i] = 7'b0000000;
        seg_table[15] = 7'b0000001;

        vecs[0] = '{pack8(2,0,0,0,0,7,1,4),    1'b0, 7'b1101101, 7'b1111110, 3};
        vecs[1] = '{pack8(1,2,3,12,5,6,7,8),   1'b1, 7'b0110000, 7'b0000001, 0};
        vecs[2] = '{pack8(9,8,7,6,5,4,3,2),    1'b0, 7'b1111011, 7'b1011111, 0};

        for (int i = 0; i < 8; i++) gen_mem[i] = 4'd0;
        start = 1'b0;
        RST_N = 1'b0;
        #12;
        checkOutput("reset_idx", idx, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_seg", seg, 0);
        checkOutput("reset_an", an, 8'hFF);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checkOutput("idle_an_blank", an, 8'hFF);

        // Table-driven loads; every load after the first restarts from SCAN
        for (int v = 0; v < 3; v++) begin
            applyStimulus(vecs[v].digits, vecs[v].restartAt);
            checkOutput($sformatf("tbl%0d_err", v), err, vecs[v].expErr);
            checkOutput($sformatf("tbl%0d_seg0", v), seg, vecs[v].expSeg0);
            checkScan(vecs[v].digits, 33, s3);
            checkOutput($sformatf("tbl%0d_seg3", v), s3, vecs[v].expSeg3);
        end

        // Reset mid-load: everything returns to idle values, no done pulse
        for (int i = 0; i < 8; i++) gen_mem[i] = 4'(i + 1);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (6) @(negedge CLK);
        @(posedge CLK);
        #1 RST_N = 1'b0;
        #1;
        checkOutput("midreset_idx", idx, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_an", an, 8'hFF);
        checkOutput("midreset_err", err, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        doneSeen = 1'b0;
        repeat (20) begin
            @(negedge CLK);
            if (done || busy) doneSeen = 1'b1;
        end
        checkOutput("midreset_no_done", doneSeen, 0);
        applyStimulus(pack8(2,0,0,0,0,7,1,4), 0);
        checkScan(pack8(2,0,0,0,0,7,1,4), 16, s3);

        // Leading-zero patterns (blanked only when the macro is defined)
        applyStimulus(pack8(0,0,0,0,0,7,1,4), 0);
        checkScan(pack8(0,0,0,0,0,7,1,4), 33, s3);
        applyStimulus(pack8(0,0,0,0,0,0,0,0), 0);
        checkScan(pack8(0,0,0,0,0,0,0,0), 33, s3);

        // Randomized loads with random ignored start pulses during the load
        for (int r = 0; r < 6; r++) begin
            rd = '0;
            for (int i = 0; i < 8; i++) begin
                int d;
                d = $urandom_range(0, 13);
                if (d >= 12) d = 0;
                rd[4*i +: 4] = 4'(d);
            end
            applyStimulus(rd, $urandom_range(0, 15));
            checkScan(rd, 33, s3);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

    // Absolute time limit so the bench can never hang
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
